// File: rtl/pe_pkg.sv
// Shared helpers for the weight-stationary PE: weight-ring width helpers and the
// wide saturating/wrapping accumulate used by the MAC datapath.
package pe_pkg;

    // Internal accumulate width; every ACC_W in use must be strictly narrower.
    localparam int unsigned PE_ACC_MAX_W = 64;

    typedef struct packed {
        logic signed [PE_ACC_MAX_W-1:0] sum;
        logic                           ovf;
    } sat_res_t;

    function automatic int unsigned wb_ptr_w(input int unsigned wbanks);
        return (wbanks > 1) ? $clog2(wbanks) : 1;
    endfunction

    function automatic int unsigned wb_cnt_w(input int unsigned wbanks);
        return $clog2(wbanks) + 1;
    endfunction

    // Operands arrive sign-extended from acc_w bits, so the wide add itself never
    // overflows; overflow is judged against the acc_w signed range instead.
    function automatic sat_res_t sat_add(input logic signed [PE_ACC_MAX_W-1:0] a,
                                         input logic signed [PE_ACC_MAX_W-1:0] b,
                                         input int unsigned                    acc_w,
                                         input logic                           saturate);
        logic signed [PE_ACC_MAX_W-1:0] full;
        logic signed [PE_ACC_MAX_W-1:0] hi;
        logic signed [PE_ACC_MAX_W-1:0] lo;
        sat_res_t                       res;
        full    = a + b;
        hi      = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo      = -hi - 64'sd1;
        res.ovf = (full > hi) || (full < lo);
        res.sum = full;
        if (saturate && (full > hi)) begin
            res.sum = hi;
        end else if (saturate && (full < lo)) begin
            res.sum = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_gen_mac.sv
// Combinational MAC: signed multiply, sign-extend, accumulate with optional clamp.
// ACC_W must lie in [2*DATA_W, PE_ACC_MAX_W-1].
module pe_gen_mac
    import pe_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 32,
    parameter int SATURATE = 0
) (
    input  logic signed [DATA_W-1:0] i_act,
    input  logic signed [DATA_W-1:0] i_weight,
    input  logic signed [ACC_W-1:0]  i_psum,
    output logic signed [ACC_W-1:0]  o_sum,
    output logic                     o_ovf
);

    logic signed [2*DATA_W-1:0]     w_prod;
    logic signed [PE_ACC_MAX_W-1:0] w_prod_x;
    logic signed [PE_ACC_MAX_W-1:0] w_psum_x;
    sat_res_t                       w_res;
    logic                           w_unused_hi;

    assign w_prod   = i_act * i_weight;
    assign w_prod_x = {{(PE_ACC_MAX_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    assign w_psum_x = {{(PE_ACC_MAX_W-ACC_W){i_psum[ACC_W-1]}}, i_psum};
    assign w_res    = sat_add(w_prod_x, w_psum_x, ACC_W, SATURATE != 0);

    // Truncation to ACC_W is what gives wrap-around when saturation is off.
    assign o_sum       = w_res.sum[ACC_W-1:0];
    assign o_ovf       = w_res.ovf;
    assign w_unused_hi = ^w_res.sum[PE_ACC_MAX_W-1:ACC_W];

endmodule

// File: rtl/pe_gen.sv
// Weight-stationary PE with a WBANKS-deep weight ring, occupancy count and sticky
// misuse flag. All east/south outputs are registered with one cycle of latency.
module pe_gen
    import pe_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 32,
    parameter int WBANKS   = 2,
    parameter int SATURATE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [DATA_W-1:0]   pe_input_in,
    input  logic                       pe_valid_in,
    input  logic                       pe_switch_in,
    input  logic signed [ACC_W-1:0]    pe_psum_in,
    input  logic signed [DATA_W-1:0]   pe_weight_in,
    input  logic                       pe_valid_w_in,
    output logic signed [ACC_W-1:0]    pe_psum_out,
    output logic signed [DATA_W-1:0]   pe_weight_out,
    output logic                       pe_valid_w_out,
    output logic signed [DATA_W-1:0]   pe_input_out,
    output logic                       pe_valid_out,
    output logic                       pe_switch_out,
    output logic                       pe_ovf_out,
    output logic [$clog2(WBANKS):0]    pe_wbuf_count,
    output logic                       pe_wbuf_err
);

    localparam int unsigned      PTR_W    = wb_ptr_w(WBANKS);
    localparam int unsigned      CNT_W    = wb_cnt_w(WBANKS);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WBANKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic signed [DATA_W-1:0] r_slot [WBANKS];
    logic [PTR_W-1:0]         r_act_ptr;
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_err;
    logic signed [ACC_W-1:0]  r_psum;
    logic                     r_ovf;
    logic signed [DATA_W-1:0] r_input;
    logic                     r_valid;
    logic                     r_switch;
    logic signed [DATA_W-1:0] r_weight;
    logic                     r_valid_w;

    logic                     w_wr_ok;
    logic                     w_sw_ok;
    logic                     w_misuse;
    logic signed [ACC_W-1:0]  w_mac;
    logic                     w_mac_ovf;

    // Both requests are judged on the pre-edge count, so same-cycle pairs cannot rescue each other.
    assign w_wr_ok  = pe_valid_w_in && (r_cnt < CNT_FULL);
    assign w_sw_ok  = pe_switch_in && (r_cnt != '0);
    assign w_misuse = (pe_valid_w_in && !w_wr_ok) || (pe_switch_in && !w_sw_ok);

    pe_gen_mac #(
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_mac (
        .i_act    (pe_input_in),
        .i_weight (r_slot[r_act_ptr]),
        .i_psum   (pe_psum_in),
        .o_sum    (w_mac),
        .o_ovf    (w_mac_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WBANKS; i++) begin
                r_slot[i] <= '0;
            end
            r_act_ptr <= '0;
            r_wr_ptr  <= PTR_ONE;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_psum    <= '0;
            r_ovf     <= 1'b0;
            r_input   <= '0;
            r_valid   <= 1'b0;
            r_switch  <= 1'b0;
            r_weight  <= '0;
            r_valid_w <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_slot[r_wr_ptr] <= pe_weight_in;
                r_wr_ptr         <= r_wr_ptr + PTR_ONE;
            end
            if (w_sw_ok) begin
                r_act_ptr <= r_act_ptr + PTR_ONE;
            end
            case ({w_wr_ok, w_sw_ok})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
            if (w_misuse) begin
                r_err <= 1'b1;
            end
            if (pe_valid_w_in) begin
                r_weight <= pe_weight_in;
            end
            r_valid_w <= pe_valid_w_in;
            r_switch  <= pe_switch_in;
            r_valid   <= pe_valid_in;
            if (pe_valid_in) begin
                r_input <= pe_input_in;
                r_psum  <= w_mac;
                r_ovf   <= w_mac_ovf;
            end else begin
                r_input <= '0;
                r_psum  <= '0;
                r_ovf   <= 1'b0;
            end
        end
    end

    assign pe_psum_out    = r_psum;
    assign pe_ovf_out     = r_ovf;
    assign pe_input_out   = r_input;
    assign pe_valid_out   = r_valid;
    assign pe_switch_out  = r_switch;
    assign pe_weight_out  = r_weight;
    assign pe_valid_w_out = r_valid_w;
    assign pe_wbuf_count  = r_cnt;
    assign pe_wbuf_err    = r_err;

endmodule

// File: tb/tb_pe_gen.sv
// Bench for pe_gen: vector table through a scoreboard on a 4-slot int8/int32 PE,
// then hand-written saturate/wrap sequences on two int8/int16 instances.
module tb_pe_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // main instance: DATA_W=8, ACC_W=32, WBANKS=4, wrap
    logic signed [7:0]  m_in = '0;
    logic               m_vi = 1'b0;
    logic               m_sw = 1'b0;
    logic signed [31:0] m_ps = '0;
    logic signed [7:0]  m_wt = '0;
    logic               m_vw = 1'b0;
    logic signed [31:0] m_psum_o;
    logic signed [7:0]  m_wt_o;
    logic               m_vw_o;
    logic signed [7:0]  m_in_o;
    logic               m_vi_o;
    logic               m_sw_o;
    logic               m_ovf_o;
    logic [2:0]         m_cnt_o;
    logic               m_err_o;

    pe_gen #(.DATA_W(8), .ACC_W(32), .WBANKS(4), .SATURATE(0)) u_dut (
        .clk(clk), .rst(rst),
        .pe_input_in(m_in), .pe_valid_in(m_vi), .pe_switch_in(m_sw),
        .pe_psum_in(m_ps), .pe_weight_in(m_wt), .pe_valid_w_in(m_vw),
        .pe_psum_out(m_psum_o), .pe_weight_out(m_wt_o), .pe_valid_w_out(m_vw_o),
        .pe_input_out(m_in_o), .pe_valid_out(m_vi_o), .pe_switch_out(m_sw_o),
        .pe_ovf_out(m_ovf_o), .pe_wbuf_count(m_cnt_o), .pe_wbuf_err(m_err_o)
    );

    // saturating and wrapping pair: DATA_W=8, ACC_W=16, WBANKS=2, shared inputs
    logic signed [7:0]  s_in = '0;
    logic               s_vi = 1'b0;
    logic               s_sw = 1'b0;
    logic signed [15:0] s_ps = '0;
    logic signed [7:0]  s_wt = '0;
    logic               s_vw = 1'b0;
    logic signed [15:0] a_psum_o, b_psum_o;
    logic signed [7:0]  a_wt_o, b_wt_o, a_in_o, b_in_o;
    logic               a_vw_o, b_vw_o, a_vi_o, b_vi_o, a_sw_o, b_sw_o;
    logic               a_ovf_o, b_ovf_o, a_err_o, b_err_o;
    logic [1:0]         a_cnt_o, b_cnt_o;

    pe_gen #(.DATA_W(8), .ACC_W(16), .WBANKS(2), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst),
        .pe_input_in(s_in), .pe_valid_in(s_vi), .pe_switch_in(s_sw),
        .pe_psum_in(s_ps), .pe_weight_in(s_wt), .pe_valid_w_in(s_vw),
        .pe_psum_out(a_psum_o), .pe_weight_out(a_wt_o), .pe_valid_w_out(a_vw_o),
        .pe_input_out(a_in_o), .pe_valid_out(a_vi_o), .pe_switch_out(a_sw_o),
        .pe_ovf_out(a_ovf_o), .pe_wbuf_count(a_cnt_o), .pe_wbuf_err(a_err_o)
    );

    pe_gen #(.DATA_W(8), .ACC_W(16), .WBANKS(2), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst),
        .pe_input_in(s_in), .pe_valid_in(s_vi), .pe_switch_in(s_sw),
        .pe_psum_in(s_ps), .pe_weight_in(s_wt), .pe_valid_w_in(s_vw),
        .pe_psum_out(b_psum_o), .pe_weight_out(b_wt_o), .pe_valid_w_out(b_vw_o),
        .pe_input_out(b_in_o), .pe_valid_out(b_vi_o), .pe_switch_out(b_sw_o),
        .pe_ovf_out(b_ovf_o), .pe_wbuf_count(b_cnt_o), .pe_wbuf_err(b_err_o)
    );

    typedef struct {
        logic rst; logic vi; int in_a; int ps; logic sw; logic vw; int wt;
        int e_ps; logic e_ovf; int e_io; logic e_vo; logic e_so; int e_wo;
        logic e_vwo; int e_cnt; logic e_err;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];
    vec_t sb_q [$];
    int   n_pop = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_main(input vec_t v);
        rst  = v.rst;
        m_vi = v.vi;
        m_in = 8'(v.in_a);
        m_ps = v.ps;
        m_sw = v.sw;
        m_vw = v.vw;
        m_wt = 8'(v.wt);
    endtask

    task automatic compare_main(input vec_t e);
        string p;
        p = $sformatf("v%0d", n_pop);
        n_pop++;
        chk({p, " psum_out"},     m_psum_o, e.e_ps);
        chk({p, " ovf_out"},      m_ovf_o,  e.e_ovf);
        chk({p, " input_out"},    m_in_o,   e.e_io);
        chk({p, " valid_out"},    m_vi_o,   e.e_vo);
        chk({p, " switch_out"},   m_sw_o,   e.e_so);
        chk({p, " weight_out"},   m_wt_o,   e.e_wo);
        chk({p, " valid_w_out"},  m_vw_o,   e.e_vwo);
        chk({p, " wbuf_count"},   m_cnt_o,  e.e_cnt);
        chk({p, " wbuf_err"},     m_err_o,  e.e_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //         rst vi  in   ps  sw vw wt   eps  eovf eio evo eso ewo evwo ecnt eerr
        tbl[0]  = '{1, 0,  0,   0,  0, 0, 0,   0,   0,   0,  0,  0,  0,  0,   0,   0};
        tbl[1]  = '{0, 0,  0,   0,  0, 1, 3,   0,   0,   0,  0,  0,  3,  1,   1,   0};
        tbl[2]  = '{0, 0,  0,   0,  1, 0, 0,   0,   0,   0,  0,  1,  3,  0,   0,   0};
        tbl[3]  = '{0, 1,  5,   10, 0, 0, 0,   25,  0,   5,  1,  0,  3,  0,   0,   0};
        tbl[4]  = '{0, 1,  5,   0,  1, 0, 0,   15,  0,   5,  1,  1,  3,  0,   0,   1};
        tbl[5]  = '{0, 1,  1,   0,  0, 0, 0,   3,   0,   1,  1,  0,  3,  0,   0,   1};
        tbl[6]  = '{1, 1,  7,   7,  1, 1, 7,   0,   0,   0,  0,  0,  0,  0,   0,   0};
        tbl[7]  = '{0, 0,  0,   0,  0, 1, 1,   0,   0,   0,  0,  0,  1,  1,   1,   0};
        tbl[8]  = '{0, 0,  0,   0,  0, 1, 2,   0,   0,   0,  0,  0,  2,  1,   2,   0};
        tbl[9]  = '{0, 0,  0,   0,  0, 1, 3,   0,   0,   0,  0,  0,  3,  1,   3,   0};
        tbl[10] = '{0, 0,  0,   0,  0, 1, 4,   0,   0,   0,  0,  0,  4,  1,   3,   1};
        tbl[11] = '{0, 0,  0,   0,  1, 0, 0,   0,   0,   0,  0,  1,  4,  0,   2,   1};
        tbl[12] = '{0, 1,  2,   0,  1, 0, 0,   2,   0,   2,  1,  1,  4,  0,   1,   1};
        tbl[13] = '{0, 1,  2,   0,  1, 0, 0,   4,   0,   2,  1,  1,  4,  0,   0,   1};
        tbl[14] = '{0, 1,  2,   0,  0, 0, 0,   6,   0,   2,  1,  0,  4,  0,   0,   1};
        tbl[15] = '{1, 0,  0,   0,  0, 0, 0,   0,   0,   0,  0,  0,  0,  0,   0,   0};
        tbl[16] = '{0, 0,  0,   0,  0, 1, 7,   0,   0,   0,  0,  0,  7,  1,   1,   0};
        tbl[17] = '{0, 0,  0,   0,  1, 1, 9,   0,   0,   0,  0,  1,  9,  1,   1,   0};
        tbl[18] = '{0, 1,  2,   100,0, 0, 0,   114, 0,   2,  1,  0,  9,  0,   1,   0};
        tbl[19] = '{0, 0,  5,   55, 1, 0, 0,   0,   0,   0,  0,  1,  9,  0,   0,   0};
        tbl[20] = '{0, 1,  -3,  0,  0, 0, 0,   -27, 0,   -3, 1,  0,  9,  0,   0,   0};
        tbl[21] = '{0, 0,  0,   0,  1, 1, 5,   0,   0,   0,  0,  1,  5,  1,   1,   1};
        tbl[22] = '{0, 1,  1,   0,  0, 0, 0,   9,   0,   1,  1,  0,  5,  0,   1,   1};
        tbl[23] = '{1, 1,  4,   0,  0, 0, 0,   0,   0,   0,  0,  0,  0,  0,   0,   0};
        tbl[24] = '{0, 1,  4,   1,  0, 0, 0,   1,   0,   4,  1,  0,  0,  0,   0,   0};

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            if (sb_q.size() > 0) compare_main(sb_q.pop_front());
            drive_main(tbl[i]);
            sb_q.push_back(tbl[i]);
        end
        @(negedge clk);
        if (sb_q.size() > 0) compare_main(sb_q.pop_front());
        drive_main(tbl[15]);
        rst = 1'b1;

        // saturate / wrap corner cases: weight -128 made active first
        @(negedge clk);
        rst  = 1'b0;
        s_vw = 1'b1;
        s_wt = -8'sd128;
        @(negedge clk);
        chk("sat count after write",  a_cnt_o, 1);
        chk("wrap count after write", b_cnt_o, 1);
        s_vw = 1'b0;
        s_sw = 1'b1;
        @(negedge clk);
        chk("sat count after switch", a_cnt_o, 0);
        chk("sat err after switch",   a_err_o, 0);
        s_sw = 1'b0;
        s_vi = 1'b1;
        s_in = -8'sd128;
        s_ps = 16'sd32767;
        @(negedge clk);
        chk("sat pos clamp psum",  a_psum_o, 32767);
        chk("sat pos clamp ovf",   a_ovf_o,  1);
        chk("wrap pos psum",       b_psum_o, -16385);
        chk("wrap pos ovf",        b_ovf_o,  1);
        s_in = 8'sd127;
        s_ps = -16'sd32768;
        @(negedge clk);
        chk("sat neg clamp psum",  a_psum_o, -32768);
        chk("sat neg clamp ovf",   a_ovf_o,  1);
        chk("wrap neg psum",       b_psum_o, 16512);
        chk("wrap neg ovf",        b_ovf_o,  1);
        s_in = 8'sd1;
        s_ps = 16'sd100;
        @(negedge clk);
        chk("sat in-range psum",   a_psum_o, -28);
        chk("sat in-range ovf",    a_ovf_o,  0);
        chk("wrap in-range psum",  b_psum_o, -28);
        chk("wrap in-range ovf",   b_ovf_o,  0);
        s_vi = 1'b0;
        s_in = 8'sd5;
        @(negedge clk);
        chk("sat invalid psum",    a_psum_o, 0);
        chk("sat invalid input",   a_in_o,   0);
        chk("sat invalid ovf",     a_ovf_o,  0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
